programmer_stream: RTL and testbench
====================================

Name: programmer_stream

Overview:
- Parametrised successor of the UART boot programmer.
- Takes validated UART bytes from the UART receiver and splits each byte into REGISTER_WIDTH-wide words, MSB or LSB word first.
- Writes the words to consecutive program-memory addresses, stops when memory is full, and reports progress, completion and overrun to the top-level control logic.
- Sits between uart_rx and the CPU program memory write port; it is active only while the CPU is held in programming mode.

Parameters:
- UART_DATA_LENGTH, 8, UART byte width in bits; must be an integer multiple of REGISTER_WIDTH.
- REGISTER_WIDTH, 4, memory word width in bits.
- MEMORY_ADDRESS_WIDTH, 4, program memory address width; memory depth is 2^MEMORY_ADDRESS_WIDTH.
- MSB_FIRST, 1, 1 = most significant word of each byte goes to the lowest address; 0 = least significant word first.
- Derived, internal only: WORDS_PER_BYTE = UART_DATA_LENGTH/REGISTER_WIDTH, which must be ≥1.

Ports:
- clk_i  in  1  system clock, all state updates on rising edge.
- reset_i  in  1  asynchronous active-high reset.
- active_i  in  1  programming mode enable; low = block idle and counters cleared.
- uart_data_i  in  UART_DATA_LENGTH  received byte, valid only while data_valid_strb_i is high.
- data_valid_strb_i  in  1  one-cycle strobe marking a new byte.
- data_o  out  REGISTER_WIDTH  word to write.
- addr_o  out  MEMORY_ADDRESS_WIDTH  write address.
- enable_write_memory_o  out  1  memory write enable.
- busy_o  out  1  high while words of the current byte are still being written.
- done_o  out  1  memory completely filled.
- overrun_o  out  1  sticky: a byte was dropped.
- word_count_o  out  MEMORY_ADDRESS_WIDTH+1  words written since activation.
- checksum_o  out  REGISTER_WIDTH  running checksum (see Optional Feature).

Behaviour:
- Reset (asynchronous): state=IDLE, byte register=0, addr=0, word index=0, word_count=0, overrun=0, checksum=0.
  - All outputs read 0 during and after reset until the first byte arrives.
- Outputs are Moore outputs decoded from registered state, so there are no glitches caused by the strobe input.
- States:
  - IDLE:
    - active_i=1 and strobe=1: capture uart_data_i into the byte register, set word index=0, go to WRITE.
    - Otherwise stay in IDLE.
  - WRITE:
    - enable_write_memory_o=1 and busy_o=1.
    - addr_o = addr.
    - data_o = word[index] of the captured byte. With MSB_FIRST=1, index 0 is bits [UART_DATA_LENGTH-1 : UART_DATA_LENGTH-REGISTER_WIDTH]; with MSB_FIRST=0, index 0 is bits [REGISTER_WIDTH-1:0].
    - Each cycle: addr+1, index+1, word_count+1.
    - After the last word (index=WORDS_PER_BYTE-1): go to FULL if addr was 2^MEMORY_ADDRESS_WIDTH-1, otherwise go to IDLE.
  - FULL:
    - done_o=1; no writes; strobes ignored.
    - Stays in FULL until active_i falls or reset.
    - The address never wraps; memory is never overwritten within one activation.
- Latency: strobe sampled at edge N → first write at cycle N+1 → last write at cycle N+WORDS_PER_BYTE. A new byte is accepted from cycle N+WORDS_PER_BYTE onward (back-to-back bytes spaced WORDS_PER_BYTE apart are lossless).
- Overrun:
  - A strobe while in WRITE, or while in FULL, drops the byte and sets overrun_o=1.
  - overrun_o stays set until active_i=0 or reset.
  - The in-flight byte completes unaffected.
- A strobe while active_i=0 is ignored and does not set overrun.
- active_i falling, from any state, takes effect on the next edge:
  - return to IDLE; addr=0, index=0, word_count=0, overrun=0, checksum=0.
  - Any partially written byte is abandoned; no further write enables are issued.
- When active_i and the strobe are both high in the first cycle after active_i rises, the byte is accepted normally.
- word_count_o reaches 2^MEMORY_ADDRESS_WIDTH exactly at FULL and never exceeds it.

Optional Feature:
- Macro PROGRAMMER_CHECKSUM_EN.
- Defined:
  - checksum register updates every WRITE cycle as checksum + data_o, modulo 2^REGISTER_WIDTH.
  - Cleared on reset or when active_i=0.
  - checksum_o presents the register value.
- Undefined: no checksum register is built; checksum_o is tied to 0. The port list is identical either way.

Test Plan:
- Defaults, active_i=1, strobe with 0xA5 at edge N → cycle N+1: addr 0, data 0xA, write enable 1; cycle N+2: addr 1, data 0x5, write enable 1; cycle N+3: IDLE, busy_o=0, word_count_o=2.
- MSB_FIRST=0, byte 0xA5 → addr 0 gets 0x5, addr 1 gets 0xA.
- Send 8 bytes 0x00..0x07 spaced 2 cycles apart → 16 writes, addresses 0..15 with no gaps, done_o=1, word_count_o=16; a 9th byte causes no write and overrun_o=1.
- Overrun: byte 0x3C, then a second strobe at cycle N+1 → only 0x3, 0xC are written, overrun_o=1; pulse active_i low → overrun_o=0, word_count_o=0, addr restarts at 0.
- Abort: drop active_i in cycle N+1 of byte 0xF0 → only addr 0 (0xF) is written, then no write enable; assert reset_i mid-WRITE → all outputs 0 immediately.
- PROGRAMMER_CHECKSUM_EN defined, bytes 0x12 then 0x34 → checksum_o=0xA; bytes 0xFF, 0xFF → 0xC (modulo wrap); macro undefined → checksum_o stays 0.

Source files
------------

// File: rtl/programmer_stream.sv
// UART byte to program-memory word streamer: splits each received byte into
// REGISTER_WIDTH words and writes them to consecutive addresses until memory is full.
// Optional running checksum of written words: define PROGRAMMER_CHECKSUM_EN.
module programmer_stream #(
    parameter int UART_DATA_LENGTH     = 8,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MSB_FIRST            = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            active_i,
    input  logic [UART_DATA_LENGTH-1:0]     uart_data_i,
    input  logic                            data_valid_strb_i,
    output logic [REGISTER_WIDTH-1:0]       data_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] addr_o,
    output logic                            enable_write_memory_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            overrun_o,
    output logic [MEMORY_ADDRESS_WIDTH:0]   word_count_o,
    output logic [REGISTER_WIDTH-1:0]       checksum_o
);

    localparam int WPB   = UART_DATA_LENGTH / REGISTER_WIDTH;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [IDX_W-1:0]                LAST_IDX  = IDX_W'(WPB - 1);
    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                          state_q;
    logic [UART_DATA_LENGTH-1:0]     byte_q;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q;
    logic [IDX_W-1:0]                idx_q;
    logic [MEMORY_ADDRESS_WIDTH:0]   count_q;
    logic                            overrun_q;
    logic [REGISTER_WIDTH-1:0]       word_sel;

    // Word index 0 is the most or least significant slice depending on MSB_FIRST.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < WPB; k++) begin
            if (idx_q == IDX_W'(k)) begin
                if (MSB_FIRST != 0)
                    word_sel = byte_q[(WPB-1-k)*REGISTER_WIDTH +: REGISTER_WIDTH];
                else
                    word_sel = byte_q[k*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else if (!active_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_valid_strb_i) begin
                        byte_q  <= uart_data_i;
                        idx_q   <= '0;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    count_q <= count_q + (MEMORY_ADDRESS_WIDTH+1)'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        if (addr_q == LAST_ADDR) begin
                            // Hold the address at the top so it never wraps.
                            state_q <= FULL;
                            if (data_valid_strb_i)
                                overrun_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + MEMORY_ADDRESS_WIDTH'(1);
                            if (data_valid_strb_i) begin
                                byte_q  <= uart_data_i;
                                state_q <= WRITE;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end else begin
                        addr_q <= addr_q + MEMORY_ADDRESS_WIDTH'(1);
                        idx_q  <= idx_q + IDX_W'(1);
                        if (data_valid_strb_i)
                            overrun_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (data_valid_strb_i)
                        overrun_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PROGRAMMER_CHECKSUM_EN
    logic [REGISTER_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            checksum_q <= '0;
        else if (!active_i)
            checksum_q <= '0;
        else if (state_q == WRITE)
            checksum_q <= checksum_q + word_sel;
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

    assign enable_write_memory_o = (state_q == WRITE);
    assign busy_o                = (state_q == WRITE);
    assign done_o                = (state_q == FULL);
    assign data_o                = (state_q == WRITE) ? word_sel : '0;
    assign addr_o                = addr_q;
    assign overrun_o             = overrun_q;
    assign word_count_o          = count_q;

endmodule

// File: tb/tb_programmer_stream.sv
// Self-checking bench for programmer_stream: queue-based reference model compared
// every cycle, directed literal checks, then randomized activity.
module tb_programmer_stream;

    localparam int UDL   = 8;
    localparam int RW    = 4;
    localparam int AW    = 4;
    localparam int MSB   = 1;
    localparam int WPB   = UDL / RW;
    localparam int DEPTH = 1 << AW;
`ifdef PROGRAMMER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           active_i;
    logic [UDL-1:0] uart_data_i;
    logic           data_valid_strb_i;
    logic [RW-1:0]  data_o;
    logic [AW-1:0]  addr_o;
    logic           enable_write_memory_o;
    logic           busy_o;
    logic           done_o;
    logic           overrun_o;
    logic [AW:0]    word_count_o;
    logic [RW-1:0]  checksum_o;

    programmer_stream #(
        .UART_DATA_LENGTH    (UDL),
        .REGISTER_WIDTH      (RW),
        .MEMORY_ADDRESS_WIDTH(AW),
        .MSB_FIRST           (MSB)
    ) dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .active_i             (active_i),
        .uart_data_i          (uart_data_i),
        .data_valid_strb_i    (data_valid_strb_i),
        .data_o               (data_o),
        .addr_o               (addr_o),
        .enable_write_memory_o(enable_write_memory_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .overrun_o            (overrun_o),
        .word_count_o         (word_count_o),
        .checksum_o           (checksum_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: words still to be written sit in a queue; the head is
    // what the memory port shows this cycle.
    int m_written;
    int m_pend[$];
    bit m_ovr;
    int m_cks;

    task automatic m_clear();
        m_written = 0;
        m_pend.delete();
        m_ovr = 1'b0;
        m_cks = 0;
    endtask

    task automatic m_step();
        int b;
        if (reset_i || !active_i) begin
            m_clear();
        end else begin
            if (m_pend.size() > 0) begin
                m_cks = (m_cks + m_pend[0]) % (1 << RW);
                m_written++;
                void'(m_pend.pop_front());
            end
            if (data_valid_strb_i) begin
                if (m_pend.size() == 0 && m_written < DEPTH) begin
                    b = int'(uart_data_i);
                    for (int k = 0; k < WPB; k++)
                        m_pend.push_back(MSB != 0 ? (b >> (UDL - RW*(k+1))) % (1 << RW)
                                                  : (b >> (RW*k)) % (1 << RW));
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk_i);
            m_step();
            @(negedge clk_i);
            if (reset_i) m_clear();
            chk("m_we",       int'(enable_write_memory_o), int'(m_pend.size() > 0));
            chk("m_busy",     int'(busy_o),               int'(m_pend.size() > 0));
            chk("m_done",     int'(done_o),               int'(m_written == DEPTH && m_pend.size() == 0));
            chk("m_overrun",  int'(overrun_o),            int'(m_ovr));
            chk("m_count",    int'(word_count_o),         m_written);
            chk("m_checksum", int'(checksum_o),           CKS_EN ? m_cks : 0);
            if (m_pend.size() > 0) begin
                chk("m_addr", int'(addr_o), m_written);
                chk("m_data", int'(data_o), m_pend[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic send(input logic [UDL-1:0] b);
        data_valid_strb_i = 1'b1;
        uart_data_i       = b;
        tick();
        data_valid_strb_i = 1'b0;
        tick();
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_data"},  int'(data_o),                0);
        chk({nm, "_addr"},  int'(addr_o),                0);
        chk({nm, "_we"},    int'(enable_write_memory_o), 0);
        chk({nm, "_busy"},  int'(busy_o),                0);
        chk({nm, "_done"},  int'(done_o),                0);
        chk({nm, "_ovr"},   int'(overrun_o),             0);
        chk({nm, "_count"}, int'(word_count_o),          0);
        chk({nm, "_cks"},   int'(checksum_o),            0);
    endtask

    initial begin
        reset_i           = 1'b1;
        active_i          = 1'b0;
        uart_data_i       = '0;
        data_valid_strb_i = 1'b0;
        repeat (3) tick();
        all_zero("reset");
        reset_i = 1'b0;
        tick();

        // 0xA5 strobed in the very first active cycle
        active_i          = 1'b1;
        data_valid_strb_i = 1'b1;
        uart_data_i       = 8'hA5;
        tick();
        data_valid_strb_i = 1'b0;
        chk("a5_we0",   int'(enable_write_memory_o), 1);
        chk("a5_addr0", int'(addr_o), 0);
        chk("a5_data0", int'(data_o), MSB != 0 ? 'hA : 'h5);
        tick();
        chk("a5_we1",   int'(enable_write_memory_o), 1);
        chk("a5_addr1", int'(addr_o), 1);
        chk("a5_data1", int'(data_o), MSB != 0 ? 'h5 : 'hA);
        tick();
        chk("a5_busy",  int'(busy_o), 0);
        chk("a5_count", int'(word_count_o), 2);

        // Fill memory with back-to-back bytes, then overflow
        active_i = 1'b0; tick(); active_i = 1'b1; tick();
        for (int i = 0; i < 8; i++) send(8'(i));
        tick();
        chk("fill_done",  int'(done_o), 1);
        chk("fill_count", int'(word_count_o), 16);
        data_valid_strb_i = 1'b1;
        uart_data_i       = 8'h99;
        tick();
        data_valid_strb_i = 1'b0;
        chk("fill_ovr", int'(overrun_o), 1);
        chk("fill_we",  int'(enable_write_memory_o), 0);
        tick();

        // Strobe during WRITE drops the byte
        active_i = 1'b0; tick(); active_i = 1'b1; tick();
        data_valid_strb_i = 1'b1;
        uart_data_i       = 8'h3C;
        tick();
        uart_data_i = 8'h55;
        tick();
        data_valid_strb_i = 1'b0;
        chk("ovr_data1", int'(data_o), MSB != 0 ? 'hC : 'h3);
        tick();
        chk("ovr_flag",  int'(overrun_o), 1);
        chk("ovr_count", int'(word_count_o), 2);
        active_i = 1'b0;
        tick();
        chk("ovr_clr",   int'(overrun_o), 0);
        chk("ovr_count0", int'(word_count_o), 0);
        active_i = 1'b1;
        tick();

        // Abort mid-byte
        data_valid_strb_i = 1'b1;
        uart_data_i       = 8'hF0;
        tick();
        data_valid_strb_i = 1'b0;
        chk("abort_data0", int'(data_o), MSB != 0 ? 'hF : 'h0);
        active_i = 1'b0;
        tick();
        chk("abort_we", int'(enable_write_memory_o), 0);
        tick();
        active_i = 1'b1;
        tick();

        // Asynchronous reset mid-WRITE
        data_valid_strb_i = 1'b1;
        uart_data_i       = 8'h81;
        tick();
        data_valid_strb_i = 1'b0;
        #1 reset_i = 1'b1;
        #1 all_zero("async_rst");
        tick();
        reset_i = 1'b0;
        tick();

        // Checksum
        send(8'h12);
        send(8'h34);
        tick();
        chk("cks_1234", int'(checksum_o), CKS_EN ? 'hA : 0);
        active_i = 1'b0; tick(); active_i = 1'b1; tick();
        send(8'hFF);
        send(8'hFF);
        tick();
        chk("cks_ffff", int'(checksum_o), CKS_EN ? 'hC : 0);

        // Randomized activity against the model
        for (int i = 0; i < 3000; i++) begin
            reset_i = ($urandom_range(299) == 0);
            if (active_i && $urandom_range(39) == 0)
                active_i = 1'b0;
            else if (!active_i && $urandom_range(3) == 0)
                active_i = 1'b1;
            data_valid_strb_i = ($urandom_range(2) == 0);
            uart_data_i       = 8'($urandom);
            tick();
        end
        reset_i           = 1'b0;
        data_valid_strb_i = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
